fft_addr_gen: RTL and testbench

- Upstream sequencer for the 4-butterfly FFT datapath.
- Walks every radix-2 DIF stage of an in-place FFT and issues one beat per cycle. Each beat carries a read address pair, the butterfly stride and four twiddle offsets.
- Each beat processes 8 samples, i.e. 4 butterflies, from two 128-bit words of 4 packed 32-bit complex samples.
- Inserts a pipeline-drain gap between stages so stage s+1 never reads a word before stage s has written it back.

---
 rtl/fft_addr_gen_if.sv | 45 ++++
 rtl/fft_addr_gen.sv | 157 +++++++++++++++
 tb/tb_fft_addr_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_addr_gen_if.sv
//==============================================================================
// Module      : fft_addr_gen_if
// Description : Start/stall control and beat bus between the FFT address
//               generator and the 4-butterfly datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fft_addr_gen_if #(
    parameter int LOG2_POINTS = 10
);
    logic                   i_start;
    logic                   i_stall;
    logic [LOG2_POINTS-3:0] o_addr1;
    logic [LOG2_POINTS-3:0] o_addr2;
    logic                   o_valid;
    logic [LOG2_POINTS-1:0] o_stride;
    logic [LOG2_POINTS-2:0] o_twiddle_offset1;
    logic [LOG2_POINTS-2:0] o_twiddle_offset2;
    logic [LOG2_POINTS-2:0] o_twiddle_offset3;
    logic [LOG2_POINTS-2:0] o_twiddle_offset4;
    logic [3:0]             o_stage;
    logic                   o_busy;
    logic                   o_done;

    // Generator side: takes control, drives beats.
    modport master (
        input  i_start, i_stall,
        output o_addr1, o_addr2, o_valid, o_stride,
        output o_twiddle_offset1, o_twiddle_offset2,
        output o_twiddle_offset3, o_twiddle_offset4,
        output o_stage, o_busy, o_done
    );

    // Consumer side: issues control, receives beats.
    modport slave (
        output i_start, i_stall,
        input  o_addr1, o_addr2, o_valid, o_stride,
        input  o_twiddle_offset1, o_twiddle_offset2,
        input  o_twiddle_offset3, o_twiddle_offset4,
        input  o_stage, o_busy, o_done
    );
endinterface

`default_nettype wire

// File: rtl/fft_addr_gen.sv
//==============================================================================
// Module      : fft_addr_gen
// Description : Stage/beat sequencer for an in-place radix-2 DIF FFT. Issues
//               one beat (two word addresses, stride, four twiddle indices)
//               per cycle, with a fixed drain gap after every stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fft_addr_gen #(
    parameter int LOG2_POINTS  = 10,
    parameter int DRAIN_CYCLES = 6
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fft_addr_gen_if.master bus
);
    localparam int AW = LOG2_POINTS - 2;   // word address width
    localparam int JW = LOG2_POINTS - 3;   // beat index width
    localparam int TW = LOG2_POINTS - 1;   // twiddle index width
    localparam int SW = LOG2_POINTS;       // sample index / stride width
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [3:0]     LAST_STAGE      = 4'(LOG2_POINTS - 1);
    // Last stage whose stride is >= 4 samples (one word or more apart).
    localparam logic [3:0]     LAST_WIDE_STAGE = 4'(LOG2_POINTS - 3);
    localparam logic [JW-1:0]  LAST_BEAT       = '1;
    localparam logic [DCW-1:0] DRAIN_LAST      = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [3:0]     stage;
    logic [JW-1:0]  beat;
    logic [DCW-1:0] drain_cnt;

    logic [3:0]     span_shift;
    logic [3:0]     split;
    logic [SW-1:0]  stride_next;
    logic [SW-1:0]  stride_mask;
    logic [SW-1:0]  sample_base;
    logic [AW-1:0]  beat_ext;
    logic [AW-1:0]  low_mask;
    logic [AW-1:0]  addr1_next;
    logic [AW-1:0]  addr2_next;
    logic [SW-1:0]  sample [4];
    logic [TW-1:0]  twiddle_next [4];

    // Beat contents for the current (stage, beat). Strides and twiddle
    // multipliers are powers of two, so everything reduces to shifts/masks.
    always_comb begin
        span_shift  = LAST_STAGE - stage;
        stride_next = SW'(1) << span_shift;
        stride_mask = stride_next - SW'(1);
        beat_ext    = AW'(beat);
        split       = LAST_WIDE_STAGE - stage;
        low_mask    = (AW'(1) << split) - AW'(1);
        if (stage <= LAST_WIDE_STAGE) begin
            // Insert a zero at bit 'split': first word of the pair, partner
            // word sits exactly stride/4 words above it.
            addr1_next  = ((beat_ext >> split) << (split + 4'd1)) | (beat_ext & low_mask);
            addr2_next  = addr1_next | (AW'(1) << split);
            sample_base = {addr1_next, 2'b00};
        end else begin
            // Both butterfly halves live in the same word; take words in pairs.
            addr1_next  = {beat, 1'b0};
            addr2_next  = {beat, 1'b1};
            sample_base = '0;
        end
        for (int b = 0; b < 4; b++) begin
            sample[b]       = (sample_base | SW'(b)) & stride_mask;
            twiddle_next[b] = TW'(sample[b] << stage);
        end
    end

    assign bus.o_stage = stage;

    // Control FSM with registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            stage                 <= '0;
            beat                  <= '0;
            drain_cnt             <= '0;
            bus.o_valid           <= 1'b0;
            bus.o_busy            <= 1'b0;
            bus.o_done            <= 1'b0;
            bus.o_addr1           <= '0;
            bus.o_addr2           <= '0;
            bus.o_stride          <= '0;
            bus.o_twiddle_offset1 <= '0;
            bus.o_twiddle_offset2 <= '0;
            bus.o_twiddle_offset3 <= '0;
            bus.o_twiddle_offset4 <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            bus.o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state      <= ISSUE;
                        stage      <= '0;
                        beat       <= '0;
                        drain_cnt  <= '0;
                        bus.o_busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!bus.i_stall) begin
                        bus.o_valid           <= 1'b1;
                        bus.o_addr1           <= addr1_next;
                        bus.o_addr2           <= addr2_next;
                        bus.o_stride          <= stride_next;
                        bus.o_twiddle_offset1 <= twiddle_next[0];
                        bus.o_twiddle_offset2 <= twiddle_next[1];
                        bus.o_twiddle_offset3 <= twiddle_next[2];
                        bus.o_twiddle_offset4 <= twiddle_next[3];
                        if (beat == LAST_BEAT) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The datapath never stalls, so the drain ignores i_stall.
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        if (stage == LAST_STAGE) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                            stage <= stage + 4'd1;
                            beat  <= '0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.o_done <= 1'b1;
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
//==============================================================================
// Module      : tb_fft_addr_gen
// Description : Self-checking bench for fft_addr_gen against an arithmetic
//               reference of the beat sequence and its issue schedule.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fft_addr_gen;
    localparam int L         = 10;
    localparam int N         = 1 << L;
    localparam int BEATS     = N / 8;
    localparam int TOTAL     = BEATS * L;
    localparam int DRAIN     = 6;
    localparam int MAXE      = 2048;
    localparam int RUN_EDGES = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_addr_gen_if #(.LOG2_POINTS(L)) bus ();

    fft_addr_gen #(.LOG2_POINTS(L), .DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit          stall_at [MAXE];
    bit          start_at [MAXE];
    logic [79:0] obs_beat [TOTAL + 200];
    int          obs_edge [TOTAL + 200];
    int          exp_edge [TOTAL];
    int          exp_done;
    int          nbeats, done_cnt, done_edge;
    logic        done_busy;

    function automatic logic [79:0] pack(int s, int a1, int a2, int st,
                                         int t1, int t2, int t3, int t4);
        return {14'd0, 4'(s), 8'(a1), 8'(a2), 10'(st), 9'(t1), 9'(t2), 9'(t3), 9'(t4)};
    endfunction

    // Reference beat straight from the address/twiddle rules.
    function automatic logic [79:0] exp_beat(int s, int j);
        int stride, half, a1, a2, m;
        int tw [4];
        stride = 1 << (L - 1 - s);
        m      = N / (2 * stride);
        if (stride >= 4) begin
            half = stride / 4;
            a1   = (j / half) * 2 * half + j % half;
            a2   = a1 + half;
            for (int b = 0; b < 4; b++) tw[b] = ((4 * a1 + b) % stride) * m;
        end else begin
            a1 = 2 * j;
            a2 = 2 * j + 1;
            for (int b = 0; b < 4; b++) tw[b] = (b % stride) * m;
        end
        return pack(s, a1, a2, stride, tw[0], tw[1], tw[2], tw[3]);
    endfunction

    // Issue schedule: each stage needs BEATS unstalled cycles, then DRAIN cycles.
    function automatic void build_schedule();
        int t, k, n;
        t = 1;
        k = 0;
        for (int s = 0; s < L; s++) begin
            n = 0;
            while (n < BEATS && t < MAXE) begin
                if (!stall_at[t]) begin
                    exp_edge[k] = t;
                    k++;
                    n++;
                end
                t++;
            end
            t += DRAIN;
        end
        exp_done = t;
    endfunction

    function automatic logic [79:0] obs_now();
        return pack(int'(bus.o_stage), int'(bus.o_addr1), int'(bus.o_addr2), int'(bus.o_stride),
                    int'(bus.o_twiddle_offset1), int'(bus.o_twiddle_offset2),
                    int'(bus.o_twiddle_offset3), int'(bus.o_twiddle_offset4));
    endfunction

    task automatic clear_stim();
        for (int e = 0; e < MAXE; e++) begin
            stall_at[e] = 1'b0;
            start_at[e] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Pulse start at edge 0, apply stall/start tables, record every beat.
    task automatic run_fft(input int edges);
        nbeats    = 0;
        done_cnt  = 0;
        done_edge = -1;
        done_busy = 1'bx;
        for (int k = 0; k < TOTAL + 200; k++) begin
            obs_beat[k] = 'x;
            obs_edge[k] = -1;
        end
        bus.i_start = 1'b1;
        bus.i_stall = stall_at[0];
        for (int e = 0; e < edges; e++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) begin
                if (nbeats < TOTAL + 200) begin
                    obs_beat[nbeats] = obs_now();
                    obs_edge[nbeats] = e;
                end
                nbeats++;
            end
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    done_busy = bus.o_busy;
                end
            end
            bus.i_start = start_at[e + 1];
            bus.i_stall = stall_at[e + 1];
        end
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        #1;
        checks++;
        if ({bus.o_addr1, bus.o_addr2, bus.o_valid, bus.o_stride, bus.o_twiddle_offset1,
             bus.o_twiddle_offset2, bus.o_twiddle_offset3, bus.o_twiddle_offset4,
             bus.o_stage, bus.o_busy, bus.o_done} !== '0) begin
            failures++;
            $display("FAIL reset_values: outputs not all zero (stage=%0d busy=%b)", bus.o_stage, bus.o_busy);
        end
        do_reset();
    endtask

    task automatic test_full_run();
        clear_stim();
        build_schedule();
        run_fft(1400);
        checks++;
        if (nbeats !== TOTAL) begin
            failures++;
            $display("FAIL full_count: got %0d beats, want %0d", nbeats, TOTAL);
        end
        for (int k = 0; k < TOTAL; k++) begin
            checks++;
            if (obs_beat[k] !== exp_beat(k / BEATS, k % BEATS) || obs_edge[k] !== exp_edge[k]) begin
                failures++;
                $display("FAIL full_beat %0d: got %h @%0d, want %h @%0d",
                         k, obs_beat[k], obs_edge[k], exp_beat(k / BEATS, k % BEATS), exp_edge[k]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_edge !== 1341 || done_busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done: got %0d pulses @%0d busy=%b, want 1 @1341 busy=0",
                     done_cnt, done_edge, done_busy);
        end
    endtask

    // Hand-picked beats from the no-stall run just captured.
    task automatic test_stage_examples();
        checks++;
        if (obs_beat[5] !== pack(0, 5, 133, 512, 20, 21, 22, 23)) begin
            failures++;
            $display("FAIL s0_beat5: got %h, want %h", obs_beat[5], pack(0, 5, 133, 512, 20, 21, 22, 23));
        end
        checks++;
        if (obs_beat[2 * BEATS + 40][65:36] !== {4'd2, 8'd72, 8'd104, 10'd128}) begin
            failures++;
            $display("FAIL s2_beat40: got %h, want stage 2 addr 72/104 stride 128",
                     obs_beat[2 * BEATS + 40][65:36]);
        end
        checks++;
        if (obs_beat[8 * BEATS + 3] !== pack(8, 6, 7, 2, 0, 256, 0, 256)) begin
            failures++;
            $display("FAIL s8_beat3: got %h, want %h", obs_beat[8 * BEATS + 3], pack(8, 6, 7, 2, 0, 256, 0, 256));
        end
        checks++;
        if (obs_beat[9 * BEATS + 17] !== pack(9, 34, 35, 1, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL s9_beat17: got %h, want %h", obs_beat[9 * BEATS + 17], pack(9, 34, 35, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_midrun();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (430) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_stage !== 4'd3) begin
            failures++;
            $display("FAIL midrun_state: got busy=%b stage=%0d, want busy=1 stage=3", bus.o_busy, bus.o_stage);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_addr1, bus.o_addr2, bus.o_valid, bus.o_stride, bus.o_twiddle_offset1,
             bus.o_twiddle_offset2, bus.o_twiddle_offset3, bus.o_twiddle_offset4,
             bus.o_stage, bus.o_busy, bus.o_done} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: outputs not zero (stage=%0d valid=%b busy=%b)",
                     bus.o_stage, bus.o_valid, bus.o_busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.o_done, bus.o_valid, bus.o_busy} !== 3'b000) begin
                failures++;
                $display("FAIL midrun_quiet %0d: got done/valid/busy=%b, want 000", c,
                         {bus.o_done, bus.o_valid, bus.o_busy});
            end
        end
        clear_stim();
        build_schedule();
        run_fft(1400);
        checks++;
        if (obs_beat[0] !== pack(0, 0, 128, 512, 0, 1, 2, 3) || obs_edge[0] !== 1 || done_edge !== 1341) begin
            failures++;
            $display("FAIL midrun_restart: got %h @%0d done@%0d, want %h @1 done@1341",
                     obs_beat[0], obs_edge[0], done_edge, pack(0, 0, 128, 512, 0, 1, 2, 3));
        end
    endtask

    task automatic test_stall_issue();
        clear_stim();
        for (int e = 145; e <= 147; e++) stall_at[e] = 1'b1;
        build_schedule();
        run_fft(1400);
        checks++;
        if (nbeats !== TOTAL || obs_edge[BEATS + 10] !== 148 || obs_edge[BEATS + 9] !== 144 || done_edge !== 1344) begin
            failures++;
            $display("FAIL stall_issue: got %0d beats, b10@%0d b9@%0d done@%0d, want %0d, 148, 144, 1344",
                     nbeats, obs_edge[BEATS + 10], obs_edge[BEATS + 9], done_edge, TOTAL);
        end
        for (int k = 0; k < TOTAL; k++) begin
            checks++;
            if (obs_beat[k] !== exp_beat(k / BEATS, k % BEATS) || obs_edge[k] !== exp_edge[k]) begin
                failures++;
                $display("FAIL stall_issue_beat %0d: got %h @%0d, want %h @%0d",
                         k, obs_beat[k], obs_edge[k], exp_beat(k / BEATS, k % BEATS), exp_edge[k]);
            end
        end
    endtask

    task automatic test_stall_drain();
        clear_stim();
        for (int e = 665; e <= 670; e++) stall_at[e] = 1'b1;
        run_fft(1400);
        checks++;
        if (nbeats !== TOTAL || obs_edge[5 * BEATS] !== 671 || obs_edge[5 * BEATS - 1] !== 664
            || done_edge !== 1341 || done_cnt !== 1) begin
            failures++;
            $display("FAIL stall_drain: got %0d beats, s5b0@%0d s4last@%0d done@%0d x%0d, want %0d, 671, 664, 1341 x1",
                     nbeats, obs_edge[5 * BEATS], obs_edge[5 * BEATS - 1], done_edge, done_cnt, TOTAL);
        end
    endtask

    task automatic test_random_stall();
        clear_stim();
        for (int e = 1; e < MAXE; e++) stall_at[e] = ($urandom_range(0, 4) == 0);
        for (int p = 0; p < 6; p++) start_at[$urandom_range(1, 1300)] = 1'b1;
        build_schedule();
        run_fft(RUN_EDGES);
        checks++;
        if (nbeats !== TOTAL || done_cnt !== 1 || done_edge !== exp_done || done_busy !== 1'b0) begin
            failures++;
            $display("FAIL random_summary: got %0d beats, %0d done @%0d busy=%b, want %0d, 1 @%0d busy=0",
                     nbeats, done_cnt, done_edge, done_busy, TOTAL, exp_done);
        end
        for (int k = 0; k < TOTAL; k++) begin
            checks++;
            if (obs_beat[k] !== exp_beat(k / BEATS, k % BEATS) || obs_edge[k] !== exp_edge[k]) begin
                failures++;
                $display("FAIL random_beat %0d: got %h @%0d, want %h @%0d",
                         k, obs_beat[k], obs_edge[k], exp_beat(k / BEATS, k % BEATS), exp_edge[k]);
            end
        end
    endtask

    task automatic test_ignore_start();
        clear_stim();
        start_at[50]   = 1'b1;   // during ISSUE
        start_at[131]  = 1'b1;   // during DRAIN
        start_at[1341] = 1'b1;   // during DONE
        start_at[1342] = 1'b1;   // back in IDLE while o_done is high
        run_fft(1400);
        checks++;
        if (done_cnt !== 1 || done_edge !== 1341 || obs_edge[TOTAL - 1] !== 1334) begin
            failures++;
            $display("FAIL ignore_start: got %0d done @%0d last@%0d, want 1 @1341 last@1334",
                     done_cnt, done_edge, obs_edge[TOTAL - 1]);
        end
        checks++;
        if (nbeats !== TOTAL + 57 || obs_edge[TOTAL] !== 1343 || obs_beat[TOTAL] !== pack(0, 0, 128, 512, 0, 1, 2, 3)) begin
            failures++;
            $display("FAIL restart_after_done: got %0d beats, first %h @%0d, want %0d, %h @1343",
                     nbeats, obs_beat[TOTAL], obs_edge[TOTAL], TOTAL + 57, pack(0, 0, 128, 512, 0, 1, 2, 3));
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stage_examples();
        test_reset_midrun();
        test_stall_issue();
        test_stall_drain();
        test_random_stall();
        test_ignore_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
